y86_insn_encoder: RTL and testbench

Serializes one decoded Y86-64 instruction, given as icode, ifun, rA, rB and valC fields, into the little-endian byte stream the fetch stage parses. Instruction length follows the same need-regids / need-valC rules the fetch decoder applies, so emitted images decode back to the same fields. The block feeds the instruction-memory write port during program load and self-test, and tracks the write address.

---
 rtl/y86_insn_encoder_if.sv | 34 +++
 rtl/y86_insn_encoder.sv | 140 ++++++++++++++
 tb/tb_y86_insn_encoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/y86_insn_encoder_if.sv
// Handshake bundle between an instruction source and the Y86-64 instruction
// encoder: field input side, byte output side and PC control.
interface y86_insn_encoder_if #(
    parameter int ADDR_W = 64
);
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [63:0]       valC;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [ADDR_W-1:0] next_pc;
    logic              invalid_err;

    // Source / sink side: supplies fields, consumes bytes.
    modport master (
        output base_load, base_addr, in_valid, icode, ifun, rA, rB, valC, out_ready,
        input  in_ready, out_valid, out_byte, out_addr, out_last, next_pc, invalid_err
    );

    // Encoder side.
    modport slave (
        input  base_load, base_addr, in_valid, icode, ifun, rA, rB, valC, out_ready,
        output in_ready, out_valid, out_byte, out_addr, out_last, next_pc, invalid_err
    );
endinterface

// File: rtl/y86_insn_encoder.sv
// Y86-64 instruction encoder: turns one set of decoded fields into the
// little-endian byte image the fetch stage parses, one byte per handshake,
// and keeps the instruction-memory write address (PC).
module y86_insn_encoder #(
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    y86_insn_encoder_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        idx;
    logic [3:0]        icode_p1;
    logic [3:0]        ifun_p1;
    logic [3:0]        ra_p1;
    logic [3:0]        rb_p1;
    logic [63:0]       valc_p1;
    logic [3:0]        len_p1;
    logic              accept;
    logic              last;

    // Instruction length in bytes; zero marks an icode the fetch stage rejects.
    function automatic logic [3:0] insn_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       insn_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: insn_len = 4'd2;
            4'h7, 4'h8:             insn_len = 4'd9;
            4'h3, 4'h4, 4'h5:       insn_len = 4'd10;
            default:                insn_len = 4'd0;
        endcase
    endfunction

    // Byte ix of the image: opcode, optional regid byte, then valC LSB first.
    function automatic logic [7:0] pick_byte(input logic [3:0] ic, input logic [3:0] ifn,
                                             input logic [3:0] ra, input logic [3:0] rb,
                                             input logic [63:0] vc, input logic [3:0] ix);
        logic       regids;
        logic [3:0] off;
        regids = (ic == 4'h2) || (ic == 4'h3) || (ic == 4'h4) || (ic == 4'h5) ||
                 (ic == 4'h6) || (ic == 4'hA) || (ic == 4'hB);
        off    = ix - (regids ? 4'd2 : 4'd1);
        if (ix == 4'd0)
            pick_byte = {ic, ifn};
        else if (regids && ix == 4'd1)
            pick_byte = {ra, rb};
        else
            pick_byte = vc[{off[2:0], 3'b000} +: 8];
    endfunction

    assign accept = (state == IDLE) && !bus.base_load && bus.in_valid;
    assign last   = (idx == len_p1 - 4'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: invalid icodes take a one-cycle detour through ERR.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (insn_len(bus.icode) != 4'd0) ? EMIT : ERR;
            EMIT: if (bus.out_ready && last) state_nxt = IDLE;
            ERR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // PC and byte index; the PC moves only on base_load or the final byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (bus.base_load)
                        pc <= bus.base_addr;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last) begin
                            pc  <= pc + ADDR_W'(len_p1);
                            idx <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

    // Field capture on accept; contents are don't-care outside EMIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            icode_p1 <= bus.icode;
            ifun_p1  <= bus.ifun;
            ra_p1    <= bus.rA;
            rb_p1    <= bus.rB;
            valc_p1  <= bus.valC;
            len_p1   <= insn_len(bus.icode);
        end
    end

    // Outputs decoded from state; byte outputs are zero whenever not emitting.
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_byte    = 8'h00;
        bus.out_addr    = '0;
        bus.out_last    = 1'b0;
        bus.invalid_err = 1'b0;
        bus.next_pc     = pc;
        case (state)
            IDLE: bus.in_ready = !bus.base_load;
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = pick_byte(icode_p1, ifun_p1, ra_p1, rb_p1, valc_p1, idx);
                bus.out_addr  = pc + ADDR_W'(idx);
                bus.out_last  = last;
            end
            ERR:  bus.invalid_err = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_y86_insn_encoder.sv
// Directed self-checking bench for y86_insn_encoder.
module tb_y86_insn_encoder;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  y86_insn_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  y86_insn_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc);
    bus.icode    = ic;
    bus.ifun     = ifn;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.valC     = vc;
    bus.in_valid = 1'b1;
  endtask

  logic [7:0] exp_irm [10];
  logic [7:0] exp_jle [9];
  logic [7:0] exp_rmm [4];
  int         hs;
  int         cyc;

  initial begin
    exp_irm = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    exp_jle = '{8'h71, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_rmm = '{8'h40, 8'h12, 8'h88, 8'h77};

    bus.base_load = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.icode     = 4'h0;
    bus.ifun      = 4'h0;
    bus.rA        = 4'hF;
    bus.rB        = 4'hF;
    bus.valC      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset / idle state
    if (bus.next_pc !== 64'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.invalid_err !== 1'b0) begin
      n_err++;
      $error("FAIL reset state: next_pc=%0h out_valid=%0b in_ready=%0b invalid_err=%0b",
             bus.next_pc, bus.out_valid, bus.in_ready, bus.invalid_err);
    end
    n_cmp++;
    chk("rst_next_pc", bus.next_pc, 64'h0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_invalid_err", bus.invalid_err, 1'b0);
    chk("rst_out_byte", bus.out_byte, 8'h00);
    chk("rst_out_addr", bus.out_addr, 64'h0);
    chk("rst_out_last", bus.out_last, 1'b0);

    // base_load 0x100 blocks in_ready, then irmovq
    bus.base_load = 1'b1;
    bus.base_addr = 64'h100;
    present(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    #1;
    chk("bl_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.base_load = 1'b0;
    #1;
    chk("bl_next_pc", bus.next_pc, 64'h100);
    chk("bl_no_accept", bus.out_valid, 1'b0);
    chk("irm_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("irm_valid", bus.out_valid, 1'b1);
      chk("irm_byte", bus.out_byte, exp_irm[i]);
      chk("irm_addr", bus.out_addr, 64'h100 + 64'(i));
      chk("irm_last", bus.out_last, (i == 9));
      chk("irm_in_ready_busy", bus.in_ready, 1'b0);
      tick();
    end
    chk("irm_next_pc", bus.next_pc, 64'h10A);
    chk("irm_done_valid", bus.out_valid, 1'b0);

    // jle with stalling consumer: ready pattern 1,0,0,1,0,0,...
    present(4'h7, 4'h1, 4'hF, 4'hF, 64'h40);
    tick();
    bus.in_valid = 1'b0;
    hs  = 0;
    cyc = 0;
    while (cyc < 40 && hs < 9) begin
      bus.out_ready = (cyc % 3 == 0);
      #1;
      chk("jle_valid", bus.out_valid, 1'b1);
      chk("jle_byte", bus.out_byte, exp_jle[hs]);
      chk("jle_addr", bus.out_addr, 64'h10A + 64'(hs));
      chk("jle_last", bus.out_last, (hs == 8));
      chk("jle_pc_hold", bus.next_pc, 64'h10A);
      if (bus.out_ready) hs++;
      tick();
      cyc++;
    end
    if (hs < 9) begin
      n_err++;
      $error("FAIL jle wait expired after %0d cycles with %0d handshakes", cyc, hs);
    end
    n_cmp++;
    chk("jle_handshakes", hs, 9);
    chk("jle_next_pc", bus.next_pc, 64'h113);
    chk("jle_done_valid", bus.out_valid, 1'b0);

    // Address wrap: nop at all-ones, then OPq at 0, 1
    bus.out_ready = 1'b1;
    bus.base_load = 1'b1;
    bus.base_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.base_load = 1'b0;
    present(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("nop_byte", bus.out_byte, 8'h10);
    chk("nop_addr", bus.out_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nop_last", bus.out_last, 1'b1);
    tick();
    chk("wrap_next_pc", bus.next_pc, 64'h0);
    present(4'h6, 4'h0, 4'h3, 4'h4, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("opq_b0", bus.out_byte, 8'h60);
    chk("opq_a0", bus.out_addr, 64'h0);
    chk("opq_l0", bus.out_last, 1'b0);
    tick();
    chk("opq_b1", bus.out_byte, 8'h34);
    chk("opq_a1", bus.out_addr, 64'h1);
    chk("opq_l1", bus.out_last, 1'b1);
    tick();
    chk("opq_next_pc", bus.next_pc, 64'h2);

    // Invalid icode 0xC: one-cycle error pulse, nothing emitted
    present(4'hC, 4'h0, 4'h1, 4'h2, 64'h55);
    #1;
    chk("inv_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("inv_err_pulse", bus.invalid_err, 1'b1);
    chk("inv_out_valid0", bus.out_valid, 1'b0);
    chk("inv_busy", bus.in_ready, 1'b0);
    tick();
    chk("inv_err_clear", bus.invalid_err, 1'b0);
    chk("inv_out_valid1", bus.out_valid, 1'b0);
    chk("inv_next_pc", bus.next_pc, 64'h2);
    chk("inv_ready_again", bus.in_ready, 1'b1);
    present(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("post_inv_valid", bus.out_valid, 1'b1);
    chk("post_inv_byte", bus.out_byte, 8'h00);
    chk("post_inv_addr", bus.out_addr, 64'h2);
    chk("post_inv_last", bus.out_last, 1'b1);
    tick();
    chk("post_inv_next_pc", bus.next_pc, 64'h3);
    chk("post_inv_err", bus.invalid_err, 1'b0);

    // rmmovq interrupted by reset after four bytes
    present(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rmm_byte", bus.out_byte, exp_rmm[i]);
      chk("rmm_addr", bus.out_addr, 64'h3 + 64'(i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmm_rst_valid", bus.out_valid, 1'b0);
    chk("rmm_rst_next_pc", bus.next_pc, 64'h0);
    chk("rmm_rst_byte", bus.out_byte, 8'h00);
    chk("rmm_rst_last", bus.out_last, 1'b0);
    present(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("halt_valid", bus.out_valid, 1'b1);
    chk("halt_byte", bus.out_byte, 8'h00);
    chk("halt_addr", bus.out_addr, 64'h0);
    chk("halt_last", bus.out_last, 1'b1);
    tick();
    chk("halt_next_pc", bus.next_pc, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
